// File: rtl/tx_os_pkg.sv
// rtl/tx_os_pkg.sv - shared selector encoding, sequencer state type and ordered-set helper
package tx_os_pkg;

    localparam logic [3:0] DSEL_SLOS1  = 4'd0;
    localparam logic [3:0] DSEL_SLOS2  = 4'd1;
    localparam logic [3:0] DSEL_G3_TS1 = 4'd2;
    localparam logic [3:0] DSEL_G3_TS2 = 4'd3;
    localparam logic [3:0] DSEL_G4_TS1 = 4'd4;
    localparam logic [3:0] DSEL_G4_TS2 = 4'd5;
    localparam logic [3:0] DSEL_G4_TS3 = 4'd6;
    localparam logic [3:0] DSEL_G4_TS4 = 4'd7;
    localparam logic [3:0] DSEL_DATA   = 4'd8;
    localparam logic [3:0] DSEL_IDLE   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DATA = 2'd2
    } seq_state_e;

    function automatic logic is_valid_os(input logic [3:0] os_type);
        return os_type <= DSEL_G4_TS4;
    endfunction

endpackage

// File: rtl/tx_os_sequencer_if.sv
// rtl/tx_os_sequencer_if.sv - command/selector bundle between LTSSM, transmit bus and sequencer
interface tx_os_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             os_req;
    logic [3:0]       os_type;
    logic [CNT_W-1:0] os_count;
    logic             data_en;
    logic             abort;
    logic             os_sent;
    logic [3:0]       d_sel;
    logic             req_ready;
    logic             os_done;
    logic             req_err;
    logic [CNT_W-1:0] sent_cnt;
    logic             data_mode;
    logic             timeout;

    modport master (
        output os_req, os_type, os_count, data_en, abort, os_sent,
        input  d_sel, req_ready, os_done, req_err, sent_cnt, data_mode, timeout
    );

    modport slave (
        input  os_req, os_type, os_count, data_en, abort, os_sent,
        output d_sel, req_ready, os_done, req_err, sent_cnt, data_mode, timeout
    );
endinterface

// File: rtl/tx_os_watchdog.sv
// rtl/tx_os_watchdog.sv - SEND-state stall counter; expires after TIMEOUT_CYCLES cycles without progress
module tx_os_watchdog
    import tx_os_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic expired_o
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = clear_i ? '0 : cnt_q + 1'b1;
        expired_o = !clear_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tx_os_sequencer.sv
// rtl/tx_os_sequencer.sv - ordered-set command sequencer driving the transmit bus selector
// TX_OS_SEQ_TIMEOUT_EN compiles in the SEND watchdog (tx_os_watchdog).
module tx_os_sequencer
    import tx_os_pkg::*;
#(
    parameter int CNT_W = 8
`ifdef TX_OS_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input logic               clk,
    input logic               rst,
    tx_os_sequencer_if.slave  bus
);
    seq_state_e       state_q, state_d;
    logic [3:0]       type_q, type_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] sent_q, sent_d, sent_inc;
    logic [3:0]       d_sel_q, d_sel_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             dmode_q, dmode_d;
    logic             tmo_q, tmo_d;
    logic             wd_expired;

`ifdef TX_OS_SEQ_TIMEOUT_EN
    // Cleared outside SEND so every entry (including back-to-back) starts from zero.
    tx_os_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   ((state_q != ST_SEND) || bus.os_sent),
        .expired_o (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        count_d  = count_q;
        sent_d   = sent_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tmo_d    = 1'b0;
        sent_inc = (sent_q == '1) ? sent_q : sent_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (bus.os_req) begin
                    if (is_valid_os(bus.os_type)) begin
                        state_d = ST_SEND;
                        type_d  = bus.os_type;
                        count_d = bus.os_count;
                        sent_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.data_en) begin
                    state_d = ST_DATA;
                end
            end
            ST_SEND: begin
                if (bus.os_sent) sent_d = sent_inc;
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.os_sent && (count_q != '0) && (sent_inc == count_q)) begin
                    done_d = 1'b1;
                    // A request already waiting is taken on the completing edge so the
                    // selector never shows idle between back-to-back commands.
                    if (bus.os_req && is_valid_os(bus.os_type)) begin
                        type_d  = bus.os_type;
                        count_d = bus.os_count;
                        sent_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (wd_expired) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (bus.abort || !bus.data_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_SEND: d_sel_d = type_d;
            ST_DATA: d_sel_d = DSEL_DATA;
            default: d_sel_d = DSEL_IDLE;
        endcase
        dmode_d = (state_d == ST_DATA);
        ready_d = (state_d == ST_IDLE) || done_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            type_q  <= '0;
            count_q <= '0;
            sent_q  <= '0;
            d_sel_q <= DSEL_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dmode_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            count_q <= count_d;
            sent_q  <= sent_d;
            d_sel_q <= d_sel_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dmode_q <= dmode_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.d_sel     = d_sel_q;
    assign bus.req_ready = ready_q;
    assign bus.os_done   = done_q;
    assign bus.req_err   = err_q;
    assign bus.sent_cnt  = sent_q;
    assign bus.data_mode = dmode_q;
    assign bus.timeout   = tmo_q;
endmodule

// File: tb/tb_tx_os_sequencer.sv
// tb/tb_tx_os_sequencer.sv - scoreboard bench for tx_os_sequencer
module tb_tx_os_sequencer;
    localparam logic [1:0] EV_DSEL = 2'd0;
    localparam logic [1:0] EV_DONE = 2'd1;
    localparam logic [1:0] EV_ERR  = 2'd2;
    localparam logic [1:0] EV_TMO  = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  exp_q[$];
    logic mon_en = 1'b0;
    logic [3:0] last_dsel = 4'd9;

    tx_os_sequencer_if #(.CNT_W(8)) bus ();

    tx_os_sequencer #(
        .CNT_W(8)
`ifdef TX_OS_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic got(input logic [1:0] k, input logic [7:0] v);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got kind %0d val %0h want nothing", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.val !== v) begin
                n_bad++;
                $display("FAIL sb_event: got kind %0d val %0h want kind %0d val %0h",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: every output event the DUT presents is matched against the queue in order.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.os_done) got(EV_DONE, 8'h00);
            if (bus.req_err) got(EV_ERR, 8'h00);
            if (bus.timeout) got(EV_TMO, 8'h00);
            if (bus.d_sel !== last_dsel) begin
                got(EV_DSEL, {3'b000, bus.data_mode, bus.d_sel});
                last_dsel = bus.d_sel;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        bus.os_sent = 1'b1;
        tick();
        bus.os_sent = 1'b0;
    endtask

    task automatic send_req(input logic [3:0] t, input logic [7:0] c);
        int budget;
        budget = 0;
        bus.os_req   = 1'b1;
        bus.os_type  = t;
        bus.os_count = c;
        while (!bus.req_ready && budget < 100) begin
            tick();
            budget++;
        end
        chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
        tick();
        bus.os_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hung want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.os_req = 0; bus.os_type = 0; bus.os_count = 0;
        bus.data_en = 0; bus.abort = 0; bus.os_sent = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_d_sel",     {28'd0, bus.d_sel}, 32'd9);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_os_done",   {31'd0, bus.os_done}, 32'd0);
        chk("rst_req_err",   {31'd0, bus.req_err}, 32'd0);
        chk("rst_sent_cnt",  {24'd0, bus.sent_cnt}, 32'd0);
        chk("rst_data_mode", {31'd0, bus.data_mode}, 32'd0);
        chk("rst_timeout",   {31'd0, bus.timeout}, 32'd0);
        tick();
        rst = 1'b1;
        mon_en = 1'b1;
        tick();

        // Type 2, count 3, sets ending every 10 cycles.
        push(EV_DSEL, 8'h02);
        send_req(4'd2, 8'd3);
        chk("t1_d_sel", {28'd0, bus.d_sel}, 32'd2);
        for (int i = 1; i <= 3; i++) begin
            repeat (9) tick();
            if (i == 3) begin
                push(EV_DONE, 8'h00);
                push(EV_DSEL, 8'h09);
            end
            pulse();
            chk("t1_sent_cnt", {24'd0, bus.sent_cnt}, i);
        end
        chk("t1_done", {31'd0, bus.os_done}, 32'd1);
        chk("t1_d_sel_idle", {28'd0, bus.d_sel}, 32'd9);
        tick();
        chk("t1_done_once", {31'd0, bus.os_done}, 32'd0);

        // Type 7 count 16, then type 5 count 2 waiting at completion.
        push(EV_DSEL, 8'h07);
        send_req(4'd7, 8'd16);
        for (int i = 0; i < 15; i++) begin
            tick();
            pulse();
        end
        chk("t2_sent15", {24'd0, bus.sent_cnt}, 32'd15);
        bus.os_req = 1'b1; bus.os_type = 4'd5; bus.os_count = 8'd2;
        tick();
        push(EV_DONE, 8'h00);
        push(EV_DSEL, 8'h05);
        pulse();
        chk("t2_b2b_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("t2_b2b_d_sel", {28'd0, bus.d_sel}, 32'd5);
        tick();
        bus.os_req = 1'b0;
        chk("t2_busy", {31'd0, bus.req_ready}, 32'd0);
        tick();
        pulse();
        tick();
        push(EV_DONE, 8'h00);
        push(EV_DSEL, 8'h09);
        pulse();
        chk("t2_idle", {28'd0, bus.d_sel}, 32'd9);

        // Continuous type 0 with 300 sets, then abort.
        tick();
        push(EV_DSEL, 8'h00);
        send_req(4'd0, 8'd0);
        for (int i = 0; i < 300; i++) begin
            pulse();
            tick();
        end
        chk("t3_saturate", {24'd0, bus.sent_cnt}, 32'd255);
        push(EV_DSEL, 8'h09);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t3_abort_d_sel", {28'd0, bus.d_sel}, 32'd9);
        chk("t3_abort_done", {31'd0, bus.os_done}, 32'd0);

        // Abort coincident with completing set.
        tick();
        push(EV_DSEL, 8'h03);
        send_req(4'd3, 8'd1);
        tick();
        push(EV_DSEL, 8'h09);
        bus.os_sent = 1'b1; bus.abort = 1'b1;
        tick();
        bus.os_sent = 1'b0; bus.abort = 1'b0;
        chk("t4_sent", {24'd0, bus.sent_cnt}, 32'd1);
        chk("t4_no_done", {31'd0, bus.os_done}, 32'd0);
        chk("t4_idle_ready", {31'd0, bus.req_ready}, 32'd1);

        // Invalid type, then data mode.
        tick();
        push(EV_ERR, 8'h00);
        bus.os_req = 1'b1; bus.os_type = 4'd10;
        tick();
        bus.os_req = 1'b0;
        chk("t5_req_err", {31'd0, bus.req_err}, 32'd1);
        chk("t5_d_sel", {28'd0, bus.d_sel}, 32'd9);
        tick();
        chk("t5_err_pulse", {31'd0, bus.req_err}, 32'd0);
        push(EV_DSEL, 8'h18);
        bus.data_en = 1'b1;
        tick();
        chk("t5_data_mode", {31'd0, bus.data_mode}, 32'd1);
        chk("t5_d_sel_data", {28'd0, bus.d_sel}, 32'd8);
        repeat (3) tick();
        push(EV_DSEL, 8'h09);
        bus.data_en = 1'b0;
        tick();
        chk("t5_data_exit", {28'd0, bus.d_sel}, 32'd9);
        chk("t5_data_mode_off", {31'd0, bus.data_mode}, 32'd0);

`ifdef TX_OS_SEQ_TIMEOUT_EN
        // Watchdog: 64 SEND cycles without os_sent.
        tick();
        push(EV_DSEL, 8'h04);
        send_req(4'd4, 8'd1);
        repeat (63) tick();
        chk("t6_pre_timeout", {31'd0, bus.timeout}, 32'd0);
        push(EV_TMO, 8'h00);
        push(EV_DSEL, 8'h09);
        tick();
        chk("t6_timeout", {31'd0, bus.timeout}, 32'd1);
        chk("t6_no_done", {31'd0, bus.os_done}, 32'd0);
        chk("t6_d_sel", {28'd0, bus.d_sel}, 32'd9);
        tick();
        push(EV_DSEL, 8'h04);
        send_req(4'd4, 8'd1);
        repeat (5) tick();
        push(EV_DSEL, 8'h09);
        rst = 1'b0;
        #1;
        chk("t6_rst_d_sel", {28'd0, bus.d_sel}, 32'd9);
        chk("t6_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("t6_rst_sent", {24'd0, bus.sent_cnt}, 32'd0);
        tick();
        rst = 1'b1;
`endif

        repeat (5) tick();
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
